// File: rtl/sobel_gradient_window.sv
// Streaming 3x3 Sobel stage for RGB pixels: two line buffers, a 3x3 window, one saturated gradient per channel.
// Optional macro SOBEL_BORDER_ZERO_EN: border pixels emit a zero-gradient beat instead of no beat.
module sobel_gradient_window #(
  parameter int IMAGE_WIDTH = 640,
  parameter bit VERTICAL    = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frame_start,
  input  logic              pixel_valid,
  input  logic [7:0]        red_in,
  input  logic [7:0]        green_in,
  input  logic [7:0]        blue_in,
  output logic              grad_valid,
  output logic signed [9:0] red_grad,
  output logic signed [9:0] green_grad,
  output logic signed [9:0] blue_grad
);

  localparam int              CW       = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
  localparam logic [CW-1:0]   LAST_COL = CW'(IMAGE_WIDTH - 1);
  localparam logic [11:0]     MAX_ROW  = 12'd4095;

  typedef struct packed {
    logic [7:0] red;
    logic [7:0] green;
    logic [7:0] blue;
  } rgb_t;

  typedef enum logic {IDLE, ACTIVE} state_t;

  // One channel of the 3x3 window, indexed [row][col] with 0 the oldest.
  typedef logic [2:0][2:0][7:0] chan_win_t;

  state_t          state;
  logic [CW-1:0]   col;
  logic [11:0]     row;
  rgb_t            lb0 [IMAGE_WIDTH];
  rgb_t            lb1 [IMAGE_WIDTH];
  rgb_t            win [3][2];

  logic            accept;
  logic            interior;
  logic [CW-1:0]   eff_col;
  logic [11:0]     eff_row;
  logic [CW-1:0]   next_col;
  logic [11:0]     next_row;
  rgb_t            pix;
  rgb_t            col_px [3];
  chan_win_t       red_win, green_win, blue_win;

  function automatic logic signed [9:0] kernel(input chan_win_t p);
    logic [11:0]        pos;
    logic [11:0]        neg;
    logic signed [11:0] g;
    if (VERTICAL) begin
      pos = 12'(p[2][0]) + {3'b0, p[2][1], 1'b0} + 12'(p[2][2]);
      neg = 12'(p[0][0]) + {3'b0, p[0][1], 1'b0} + 12'(p[0][2]);
    end else begin
      pos = 12'(p[0][2]) + {3'b0, p[1][2], 1'b0} + 12'(p[2][2]);
      neg = 12'(p[0][0]) + {3'b0, p[1][0], 1'b0} + 12'(p[2][0]);
    end
    // Both sums are at most 1020, so the modulo-4096 difference is the exact signed result.
    g = $signed(pos - neg);
    if (g > 12'sd511)       return 10'sh1FF;
    else if (g < -12'sd512) return 10'sh200;
    else                    return g[9:0];
  endfunction

  // A frame_start beat is always position (0,0), whether it starts or restarts a frame.
  always_comb begin
    pix       = {red_in, green_in, blue_in};
    accept    = pixel_valid && (state == ACTIVE || frame_start);
    eff_col   = frame_start ? '0 : col;
    eff_row   = frame_start ? '0 : row;
    interior  = (eff_row >= 12'd2) && (eff_col >= CW'(2));
    next_col  = (eff_col == LAST_COL) ? '0 : eff_col + 1'b1;
    next_row  = (eff_col == LAST_COL && eff_row != MAX_ROW) ? eff_row + 12'd1 : eff_row;
    col_px[0] = lb1[eff_col];
    col_px[1] = lb0[eff_col];
    col_px[2] = pix;
    red_win   = '0;
    green_win = '0;
    blue_win  = '0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 2; j++) begin
        red_win[i][j]   = win[i][j].red;
        green_win[i][j] = win[i][j].green;
        blue_win[i][j]  = win[i][j].blue;
      end
      red_win[i][2]   = col_px[i].red;
      green_win[i][2] = col_px[i].green;
      blue_win[i][2]  = col_px[i].blue;
    end
  end

  // NOTE: line buffers and window carry no reset; the row/col qualification keeps stale data out of every valid beat.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb1[eff_col] <= lb0[eff_col];
      lb0[eff_col] <= pix;
      for (int i = 0; i < 3; i++) begin
        win[i][0] <= win[i][1];
        win[i][1] <= col_px[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      col        <= '0;
      row        <= '0;
      grad_valid <= 1'b0;
      red_grad   <= '0;
      green_grad <= '0;
      blue_grad  <= '0;
    end else begin
      grad_valid <= 1'b0;
      if (accept) begin
        state <= ACTIVE;
        col   <= next_col;
        row   <= next_row;
`ifdef SOBEL_BORDER_ZERO_EN
        grad_valid <= 1'b1;
        red_grad   <= interior ? kernel(red_win)   : '0;
        green_grad <= interior ? kernel(green_win) : '0;
        blue_grad  <= interior ? kernel(blue_win)  : '0;
`else
        if (interior) begin
          grad_valid <= 1'b1;
          red_grad   <= kernel(red_win);
          green_grad <= kernel(green_win);
          blue_grad  <= kernel(blue_win);
        end
`endif
      end
    end
  end

endmodule
